spi_slave_ctrl: RTL and testbench

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

---
 rtl/spi_ctrl_pkg.sv | 26 ++
 rtl/spi_edge_detect.sv | 70 +++++++
 rtl/spi_slave_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI slave controller.
//
// Contents:
//   DATA_WIDTH_DEFAULT - default word length in bits
//   state_e            - controller state encoding (IDLE, LOAD, SHIFT, DONE)
//   sample_on_rise()   - returns 1 when the sample edge of the mode given by
//                        (cpol, cpha) is the rising sclk edge
package spi_ctrl_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The leading edge is rising when sclk idles low (CPOL=0). The sample
    // edge is the leading edge for CPHA=0 and the trailing one for CPHA=1,
    // so the sample edge is rising exactly when CPOL and CPHA agree.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Input conditioning and edge detection for one asynchronous SPI pin.
//
// Configuration macro: SPI_SLAVE_CTRL_SYNC_EN
//   defined   - the pin passes through a two-flop synchroniser, and a third
//               flop holds the previous synchronised value; a pin change
//               reaches the consumer's registers 3 pclk cycles later.
//   undefined - the pin is registered once and compared with its live
//               value; a pin change reaches the consumer's registers on
//               the next pclk edge.
//
// Ports:
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset
//   d_i     - raw pin
//   level_o - conditioned pin level
//   rise_o  - one-cycle pulse on a 0->1 transition of level_o
//   fall_o  - one-cycle pulse on a 1->0 transition of level_o
module spi_edge_detect #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

`ifdef SPI_SLAVE_CTRL_SYNC_EN
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-flop synchroniser followed by a history flop for edge detection.
    // All stages reset to the pin's idle level so that leaving reset does
    // not fabricate an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;
`else
    logic prev_q;

    // Single history flop; the live pin is compared against it so the
    // consumer acts on the very next clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= d_i;
        end
    end

    assign level_o = d_i;
    assign rise_o  = d_i & ~prev_q;
    assign fall_o  = ~d_i & prev_q;
`endif

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: one word per LOAD/SHIFT/DONE pass, back-to-back
// words while cs_n stays low, one-entry transmit holding register.
//
// Configuration macro: SPI_SLAVE_CTRL_SYNC_EN
//   defined   - cs_n, sclk and mosi each pass a two-flop synchroniser
//               (edge-to-action latency 3 pclk cycles)
//   undefined - inputs registered once for edge detection (latency 1)
//
// Parameters:
//   DATA_WIDTH - bits per word (4..32)
//   CPOL       - sclk idle level
//   CPHA       - 0: sample on leading edge, 1: sample on trailing edge
//   MSB_FIRST  - 1: most significant bit first on both miso and mosi
//
// Ports:
//   pclk, areset      - system clock, asynchronous active-high reset
//   cs_n, sclk, mosi  - SPI bus inputs (asynchronous to pclk)
//   miso, miso_oe     - serial data out and its output enable
//   tx_data/valid/ready - transmit handshake into the holding register
//   rx_data, rx_valid - last completed received word and its strobe
//   busy              - controller is not in IDLE
//   err_underrun      - LOAD found the holding register empty
//   err_abort         - cs_n rose after part of a word had been received
module spi_slave_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cs_n,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  err_underrun,
    output logic                  err_abort
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_smp;
    logic sample_edge;
    logic shift_edge;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic                    hold_valid_q;
    logic [DATA_WIDTH-1:0]   tx_shift_q;
    logic [DATA_WIDTH-1:0]   rx_shift_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic                    miso_q;
    logic                    miso_oe_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic                    rx_valid_q;
    logic                    err_underrun_q;
    logic                    err_abort_q;
    logic                    cs_armed_q;

    logic [DATA_WIDTH-1:0]   load_word_d;
    logic [DATA_WIDTH-1:0]   load_shift_d;
    logic                    load_bit_d;
    logic [DATA_WIDTH-1:0]   tx_shift_d;
    logic                    tx_bit_d;
    logic [DATA_WIDTH-1:0]   rx_shift_d;

    spi_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_cs_edge (
        .clk_i   (pclk),
        .rst_i   (areset),
        .d_i     (cs_n),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_edge_detect #(
        .RESET_VAL (CPOL)
    ) u_sclk_edge (
        .clk_i   (pclk),
        .rst_i   (areset),
        .d_i     (sclk),
        .level_o (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

`ifdef SPI_SLAVE_CTRL_SYNC_EN
    logic mosi_meta_q;
    logic mosi_sync_q;

    // mosi gets the same two-flop delay as sclk so the sampled bit lines up
    // with the detected sample edge.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign mosi_smp = mosi_sync_q;
`else
    assign mosi_smp = mosi;
`endif

    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

    // Shift-register arithmetic for both bit orders. tx_shift_q always holds
    // the bits not yet presented on miso, so a shift edge presents its head
    // bit and drops it. An empty holding register loads zeros.
    always_comb begin
        load_word_d = hold_valid_q ? hold_q : '0;
        if (MSB_FIRST) begin
            load_bit_d   = load_word_d[DATA_WIDTH-1];
            load_shift_d = {load_word_d[DATA_WIDTH-2:0], 1'b0};
            tx_bit_d     = tx_shift_q[DATA_WIDTH-1];
            tx_shift_d   = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            rx_shift_d   = {rx_shift_q[DATA_WIDTH-2:0], mosi_smp};
        end else begin
            load_bit_d   = load_word_d[0];
            load_shift_d = {1'b0, load_word_d[DATA_WIDTH-1:1]};
            tx_bit_d     = tx_shift_q[0];
            tx_shift_d   = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
            rx_shift_d   = {mosi_smp, rx_shift_q[DATA_WIDTH-1:1]};
        end
    end

    // Controller FSM with all outputs registered.
    // cs_armed_q blocks frames until cs_n has been seen high after reset:
    // the cs edge detector resets to "high", so a cs_n already held low when
    // reset is released would otherwise look like a fresh falling edge.
    // A cs_n rise before any bit of the current word has been sampled (for
    // example, between back-to-back words) ends the frame silently; only a
    // partially received word counts as aborted.
    // The tx handshake is evaluated after the state case so a capture in
    // the same cycle as LOAD wins over LOAD's clearing of hold_valid_q.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            hold_valid_q   <= 1'b0;
            tx_shift_q     <= '0;
            rx_shift_q     <= '0;
            bit_cnt_q      <= '0;
            miso_q         <= 1'b0;
            miso_oe_q      <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            err_underrun_q <= 1'b0;
            err_abort_q    <= 1'b0;
            cs_armed_q     <= 1'b0;
        end else begin
            rx_valid_q     <= 1'b0;
            err_underrun_q <= 1'b0;
            err_abort_q    <= 1'b0;
            miso_oe_q      <= ~cs_level;
            if (cs_level) begin
                cs_armed_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall && cs_armed_q) begin
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    hold_valid_q   <= 1'b0;
                    err_underrun_q <= ~hold_valid_q;
                    bit_cnt_q      <= '0;
                    if (!CPHA) begin
                        miso_q     <= load_bit_d;
                        tx_shift_q <= load_shift_d;
                    end else begin
                        tx_shift_q <= load_word_d;
                    end
                    state_q <= cs_level ? IDLE : SHIFT;
                end

                SHIFT: begin
                    if (cs_rise) begin
                        err_abort_q <= (bit_cnt_q != '0);
                        state_q     <= IDLE;
                    end else begin
                        if (shift_edge) begin
                            miso_q     <= tx_bit_d;
                            tx_shift_q <= tx_shift_d;
                        end
                        if (sample_edge) begin
                            rx_shift_q <= rx_shift_d;
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= DONE;
                            end
                        end
                    end
                end

                DONE: begin
                    rx_data_q  <= rx_shift_q;
                    rx_valid_q <= 1'b1;
                    state_q    <= cs_level ? IDLE : LOAD;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (tx_valid && !hold_valid_q) begin
                hold_q       <= tx_data;
                hold_valid_q <= 1'b1;
            end
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = miso_oe_q;
    assign tx_ready     = ~hold_valid_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign busy         = (state_q != IDLE);
    assign err_underrun = err_underrun_q;
    assign err_abort    = err_abort_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed testbench for spi_slave_ctrl. dut0 runs SPI mode 0, dut3 runs
// mode 3; both share cs_n, mosi and tx_data, each has its own sclk and
// tx_valid. The bench plays the SPI master and checks against hand-computed
// values. Build with and without SPI_SLAVE_CTRL_SYNC_EN.
module tb_spi_slave_ctrl;

`ifdef SPI_SLAVE_CTRL_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int HALF = 6;

   logic pclk;
   logic areset;
   logic csN;
   logic sclk0;
   logic sclk3;
   logic mosi;
   logic [7:0] txData;
   logic txValid0;
   logic txValid3;

   logic miso0, misoOe0, txReady0, rxValid0, busy0, errUnderrun0, errAbort0;
   logic miso3, misoOe3, txReady3, rxValid3, busy3, errUnderrun3, errAbort3;
   logic [7:0] rxData0;
   logic [7:0] rxData3;

   int checkCount = 0;
   int failCount = 0;
   int rxCnt0 = 0, urCnt0 = 0, abCnt0 = 0;
   int rxCnt3 = 0, urCnt3 = 0, abCnt3 = 0;

   spi_slave_ctrl #(
      .DATA_WIDTH (8),
      .CPOL       (1'b0),
      .CPHA       (1'b0),
      .MSB_FIRST  (1'b1)
   ) dut0 (
      .pclk         (pclk),
      .areset       (areset),
      .cs_n         (csN),
      .sclk         (sclk0),
      .mosi         (mosi),
      .miso         (miso0),
      .miso_oe      (misoOe0),
      .tx_data      (txData),
      .tx_valid     (txValid0),
      .tx_ready     (txReady0),
      .rx_data      (rxData0),
      .rx_valid     (rxValid0),
      .busy         (busy0),
      .err_underrun (errUnderrun0),
      .err_abort    (errAbort0)
   );

   spi_slave_ctrl #(
      .DATA_WIDTH (8),
      .CPOL       (1'b1),
      .CPHA       (1'b1),
      .MSB_FIRST  (1'b1)
   ) dut3 (
      .pclk         (pclk),
      .areset       (areset),
      .cs_n         (csN),
      .sclk         (sclk3),
      .mosi         (mosi),
      .miso         (miso3),
      .miso_oe      (misoOe3),
      .tx_data      (txData),
      .tx_valid     (txValid3),
      .tx_ready     (txReady3),
      .rx_data      (rxData3),
      .rx_valid     (rxValid3),
      .busy         (busy3),
      .err_underrun (errUnderrun3),
      .err_abort    (errAbort3)
   );

   // Free-running system clock.
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Pulse counters; scenarios compare differences taken across a window.
   always @(posedge pclk) begin
      if (rxValid0) rxCnt0 <= rxCnt0 + 1;
      if (errUnderrun0) urCnt0 <= urCnt0 + 1;
      if (errAbort0) abCnt0 <= abCnt0 + 1;
      if (rxValid3) rxCnt3 <= rxCnt3 + 1;
      if (errUnderrun3) urCnt3 <= urCnt3 + 1;
      if (errAbort3) abCnt3 <= abCnt3 + 1;
   end

   // Hard stop in case a scenario stalls.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // Half an sclk period; optionally records how many pclk cycles after the
   // preceding sample edge rx_valid of the selected dut was first seen.
   task automatic waitHalf(input bit m3, input bit watch, inout int lat);
      for (int c = 1; c <= HALF; c++) begin
         @(posedge pclk);
         #1;
         if (watch && lat < 0 && (m3 ? rxValid3 : rxValid0)) lat = c;
      end
   endtask

   // Push one word into the selected dut's holding register.
   task automatic loadTx(input bit m3, input logic [7:0] d);
      int n;
      n = 0;
      while (!(m3 ? txReady3 : txReady0) && n < 50) begin
         @(posedge pclk);
         #1;
         n++;
      end
      checkOutput(m3 ? "txReadyWait3" : "txReadyWait0", m3 ? txReady3 : txReady0, 1);
      txData = d;
      if (m3) txValid3 = 1'b1; else txValid0 = 1'b1;
      @(posedge pclk);
      #1;
      txValid0 = 1'b0;
      txValid3 = 1'b0;
   endtask

   // Master side of one word, MSB first: nbits clock pulses, returns the
   // bits read from miso and the rx_valid latency after the last sample edge.
   task automatic applyStimulus(input bit m3, input int nbits, input logic [7:0] mosiWord,
                                output logic [7:0] misoWord, output int rxLat);
      int lat;
      lat = -1;
      misoWord = 8'h00;
      if (!m3) begin
         mosi = mosiWord[7];
         waitHalf(m3, 1'b0, lat);
         for (int i = 0; i < nbits; i++) begin
            misoWord[7-i] = miso0;
            sclk0 = 1'b1;
            waitHalf(m3, (i == nbits - 1), lat);
            sclk0 = 1'b0;
            if (i < 7) mosi = mosiWord[6-i];
            waitHalf(m3, 1'b0, lat);
         end
      end else begin
         waitHalf(m3, 1'b0, lat);
         for (int i = 0; i < nbits; i++) begin
            sclk3 = 1'b0;
            mosi = mosiWord[7-i];
            waitHalf(m3, 1'b0, lat);
            misoWord[7-i] = miso3;
            sclk3 = 1'b1;
            waitHalf(m3, (i == nbits - 1), lat);
         end
      end
      rxLat = lat;
   endtask

   logic [7:0] misoW;
   int lat;
   int u0, v0, a0, u3, v3, a3;
   int n;

   initial begin
      areset = 1'b1;
      csN = 1'b1;
      sclk0 = 1'b0;
      sclk3 = 1'b1;
      mosi = 1'b0;
      txData = 8'h00;
      txValid0 = 1'b0;
      txValid3 = 1'b0;
      #1;

      // Reset state
      checkOutput("rstBusy", busy0, 0);
      checkOutput("rstTxReady", txReady0, 1);
      checkOutput("rstMisoOe", misoOe0, 0);
      checkOutput("rstMiso", miso0, 0);
      checkOutput("rstRxData", rxData0, 0);
      checkOutput("rstRxValid", rxValid0, 0);
      repeat (3) @(posedge pclk);
      #1;
      areset = 1'b0;
      waitCycles(3);

      $display("[TB] mode 0 word, tx 0xA5 rx 0x3C");
      loadTx(1'b0, 8'hA5);
      checkOutput("aTxReadyFull", txReady0, 0);
      u0 = urCnt0; v0 = rxCnt0; a0 = abCnt0;
      csN = 1'b0;
      waitCycles(8);
      checkOutput("aBusy", busy0, 1);
      checkOutput("aMisoOe", misoOe0, 1);
      checkOutput("aNoUnderrun", urCnt0 - u0, 0);
      applyStimulus(1'b0, 8, 8'h3C, misoW, lat);
      checkOutput("aMiso", misoW, 8'hA5);
      checkOutput("aRxData", rxData0, 8'h3C);
      checkOutput("aRxLatency", lat, LAT + 1);
      checkOutput("aRxCount", rxCnt0 - v0, 1);
      csN = 1'b1;
      waitCycles(10);
      checkOutput("aIdle", busy0, 0);
      checkOutput("aMisoOeOff", misoOe0, 0);
      checkOutput("aNoAbort", abCnt0 - a0, 0);

      $display("[TB] mode 3 back-to-back words");
      u3 = urCnt3; v3 = rxCnt3; a3 = abCnt3;
      loadTx(1'b1, 8'h12);
      csN = 1'b0;
      waitCycles(8);
      checkOutput("bMisoOe", misoOe3, 1);
      loadTx(1'b1, 8'h34);
      applyStimulus(1'b1, 8, 8'hFF, misoW, lat);
      checkOutput("bMiso1", misoW, 8'h12);
      checkOutput("bRxData1", rxData3, 8'hFF);
      checkOutput("bRxLatency", lat, LAT + 1);
      loadTx(1'b1, 8'h56);
      applyStimulus(1'b1, 8, 8'h00, misoW, lat);
      checkOutput("bMiso2", misoW, 8'h34);
      checkOutput("bRxData2", rxData3, 8'h00);
      csN = 1'b1;
      waitCycles(10);
      checkOutput("bRxCount", rxCnt3 - v3, 2);
      checkOutput("bNoUnderrun", urCnt3 - u3, 0);
      checkOutput("bNoAbort", abCnt3 - a3, 0);
      checkOutput("bIdle", busy3, 0);

      $display("[TB] mode 0 underrun");
      u0 = urCnt0;
      csN = 1'b0;
      waitCycles(8);
      checkOutput("cUnderrun", urCnt0 - u0, 1);
      applyStimulus(1'b0, 8, 8'h81, misoW, lat);
      checkOutput("cMisoZero", misoW, 8'h00);
      checkOutput("cRxData", rxData0, 8'h81);
      csN = 1'b1;
      waitCycles(10);

      $display("[TB] mode 0 abort after 5 bits");
      loadTx(1'b0, 8'h5A);
      a0 = abCnt0; v0 = rxCnt0;
      csN = 1'b0;
      waitCycles(8);
      applyStimulus(1'b0, 5, 8'hF0, misoW, lat);
      checkOutput("dBusyBefore", busy0, 1);
      csN = 1'b1;
      n = 0;
      while (busy0 && n < 20) begin
         @(posedge pclk);
         #1;
         n++;
      end
      checkOutput("dBusyDropFast", (n <= LAT + 1), 1);
      waitCycles(4);
      checkOutput("dAbortCount", abCnt0 - a0, 1);
      checkOutput("dNoRxValid", rxCnt0 - v0, 0);
      checkOutput("dRxDataKept", rxData0, 8'h81);

      $display("[TB] reset mid-word");
      loadTx(1'b0, 8'h77);
      csN = 1'b0;
      waitCycles(8);
      applyStimulus(1'b0, 3, 8'hAA, misoW, lat);
      checkOutput("eBusyPre", busy0, 1);
      a0 = abCnt0; u0 = urCnt0; v0 = rxCnt0;
      #3;
      areset = 1'b1;
      #1;
      checkOutput("eRstMiso", miso0, 0);
      checkOutput("eRstMisoOe", misoOe0, 0);
      checkOutput("eRstTxReady", txReady0, 1);
      checkOutput("eRstRxData", rxData0, 0);
      checkOutput("eRstRxValid", rxValid0, 0);
      checkOutput("eRstBusy", busy0, 0);
      checkOutput("eRstErrAbort", errAbort0, 0);
      checkOutput("eRstErrUnderrun", errUnderrun0, 0);
      repeat (2) @(posedge pclk);
      #1;
      areset = 1'b0;
      waitCycles(3);
      applyStimulus(1'b0, 8, 8'h3C, misoW, lat);
      waitCycles(4);
      checkOutput("eNoRxAfterRst", rxCnt0 - v0, 0);
      checkOutput("eStayIdle", busy0, 0);
      checkOutput("eNoAbortAfterRst", abCnt0 - a0, 0);
      loadTx(1'b0, 8'h99);
      csN = 1'b1;
      waitCycles(6);
      csN = 1'b0;
      waitCycles(8);
      applyStimulus(1'b0, 8, 8'hC3, misoW, lat);
      checkOutput("eMiso", misoW, 8'h99);
      checkOutput("eRxData", rxData0, 8'hC3);
      checkOutput("eRxCount", rxCnt0 - v0, 1);
      csN = 1'b1;
      waitCycles(10);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
